// File: rtl/alu_share_arb4.sv
// alu_share_arb4: one registered 32-bit ALU shared by four requesters.
// Requesters are served round-robin, one operation at a time, in three
// phases: IDLE (grant and latch operands), EXEC (evaluate and register the
// result), RESP (hold the result until the owner accepts it).
// Optional feature macro: ALU_SHARE_STATS_EN (per-requester completion counters).
module alu_share_arb4 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]        req_op,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [DATA_WIDTH-1:0]       resp_result,
    output logic                        resp_overflow,
    output logic                        resp_carryout,
    output logic                        resp_zero,
    output logic                        busy,
    output logic [1:0]                  grant_id,
    output logic [NUM_REQ*16-1:0]       stat_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t                state_q, state_d;
    logic [1:0]            rr_ptr;
    logic [1:0]            sel_id;
    logic                  sel_valid;
    logic                  accept;
    logic                  resp_fire;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [2:0]            op_q;

    // ALU intermediate values
    logic                  sub_op;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum_ext;
    logic                  alu_ovf, alu_co;
    logic [DATA_WIDTH-1:0] alu_res;

    // Round-robin pick: first valid bit scanning rr_ptr, rr_ptr+1, ... mod 4.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_valid = 1'b0;
        sel_id    = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_ptr + 2'(k)]) begin
                sel_valid = 1'b1;
                sel_id    = rr_ptr + 2'(k);
            end
        end
    end

    assign accept    = (state_q == IDLE) && sel_valid && !rst;
    assign resp_fire = (state_q == RESP) && resp_ready[grant_id];
    assign req_ready = accept ? (NUM_REQ'(1) << sel_id) : '0;
    assign resp_valid = (state_q == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> EXEC on a grant, EXEC -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready[grant_id]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared ALU on the latched operands; flags always come from the adder.
    always_comb begin
        sub_op  = (op_q == OP_SUB) || (op_q == OP_SLT);
        b_eff   = sub_op ? ~b_q : b_q;
        sum_ext = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_op};
        alu_ovf = (a_q[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                  (sum_ext[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
        // Carry for ADD, borrow (unsigned A<B) for SUB/SLT.
        alu_co  = sub_op ? ~sum_ext[DATA_WIDTH] : sum_ext[DATA_WIDTH];
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD:  alu_res = sum_ext[DATA_WIDTH-1:0];
            OP_SUB:  alu_res = sum_ext[DATA_WIDTH-1:0];
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, sum_ext[DATA_WIDTH-1] ^ alu_ovf};
            default: alu_res = '0;
        endcase
    end

    // Datapath: grant capture in IDLE, result capture in EXEC, pointer advance on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= 2'd0;
            grant_id      <= 2'd0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_carryout <= 1'b0;
            resp_zero     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (accept) begin
                grant_id <= sel_id;
                a_q      <= req_a[sel_id*DATA_WIDTH +: DATA_WIDTH];
                b_q      <= req_b[sel_id*DATA_WIDTH +: DATA_WIDTH];
                op_q     <= req_op[sel_id*3 +: 3];
            end
            if (state_q == EXEC) begin
                resp_result   <= alu_res;
                resp_overflow <= alu_ovf;
                resp_carryout <= alu_co;
                resp_zero     <= (alu_res == '0);
            end
            if (resp_fire) rr_ptr <= grant_id + 2'd1;
        end
    end

`ifdef ALU_SHARE_STATS_EN
    logic [NUM_REQ*16-1:0] stat_q;

    // Completion counters, one per requester, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (resp_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == 2'(i)) stat_q[i*16 +: 16] <= stat_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb4.sv
// Directed bench for alu_share_arb4: reset, single op, round-robin order,
// ALU flags, response back-pressure, reset mid-operation and the optional
// completion counters (ALU_SHARE_STATS_EN).
module tb_alu_share_arb4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [11:0]  req_op;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  resp_result;
    logic         resp_overflow;
    logic         resp_carryout;
    logic         resp_zero;
    logic         busy;
    logic [1:0]   grant_id;
    logic [63:0]  stat_count;

    int checks = 0;
    int errors = 0;

    alu_share_arb4 dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_carryout (resp_carryout),
        .resp_zero     (resp_zero),
        .busy          (busy),
        .grant_id      (grant_id),
        .stat_count    (stat_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one op for requester id to completion and returns the response.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output logic [31:0] res,
                          output logic ovf, output logic co, output logic z);
        int waited = 0;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_op[id*3 +: 3]  = op;
        req_valid = 4'(1) << id;
        #1;
        while (req_ready[id] !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (req_ready[id] !== 1'b1) begin
            errors++;
            $display("FAIL run_op_grant id=%0d req_ready=%b required bit set", id, req_ready);
        end
        tick();
        req_valid = 4'b0;
        tick();
        checks++;
        if (resp_valid !== (4'(1) << id)) begin
            errors++;
            $display("FAIL run_op_resp_valid id=%0d got %b required %b", id, resp_valid, 4'(1) << id);
        end
        res = resp_result; ovf = resp_overflow; co = resp_carryout; z = resp_zero;
        resp_ready = 4'(1) << id;
        tick();
        resp_ready = 4'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0; resp_ready = 4'b0;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (req_ready !== 4'b0 || resp_valid !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl req_ready=%b resp_valid=%b busy=%b grant=%0d required all 0",
                     req_ready, resp_valid, busy, grant_id);
        end
        checks++;
        if (resp_result !== 32'h0 || {resp_overflow, resp_carryout, resp_zero} !== 3'b000 ||
            stat_count !== 64'h0) begin
            errors++;
            $display("FAIL reset_data result=%h flags=%b stat=%h required 0",
                     resp_result, {resp_overflow, resp_carryout, resp_zero}, stat_count);
        end
    endtask

    task automatic test_single_op();
        req_a[2*32 +: 32] = 32'h7FFFFFFF;
        req_b[2*32 +: 32] = 32'h1;
        req_op[2*3 +: 3]  = 3'b010;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_req_ready got %b required 0100", req_ready);
        end
        tick();
        req_valid = 4'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd2 || resp_valid !== 4'b0) begin
            errors++;
            $display("FAIL single_exec req_ready=%b busy=%b grant=%0d resp_valid=%b required 0000/1/2/0000",
                     req_ready, busy, grant_id, resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_result !== 32'h80000000) begin
            errors++;
            $display("FAIL single_resp resp_valid=%b result=%h required 0100/80000000", resp_valid, resp_result);
        end
        checks++;
        if ({resp_overflow, resp_carryout, resp_zero} !== 3'b100) begin
            errors++;
            $display("FAIL single_flags ovf/co/z=%b required 100", {resp_overflow, resp_carryout, resp_zero});
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = 4'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0) begin
            errors++; $display("FAIL single_done busy=%b resp_valid=%b required 0/0000", busy, resp_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 10);
            req_b[i*32 +: 32] = 32'h1;
            req_op[i*3 +: 3]  = 3'b010;
        end
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            int exp_id = g % 4;
            checks++;
            if (req_ready !== (4'(1) << exp_id)) begin
                errors++;
                $display("FAIL rr_grant%0d req_ready=%b required %b", g, req_ready, 4'(1) << exp_id);
            end
            tick();
            checks++;
            if (req_ready !== 4'b0 || grant_id !== 2'(exp_id)) begin
                errors++;
                $display("FAIL rr_exec%0d req_ready=%b grant=%0d required 0000/%0d", g, req_ready, grant_id, exp_id);
            end
            tick();
            checks++;
            if (resp_valid !== (4'(1) << exp_id) || resp_result !== 32'(exp_id + 11)) begin
                errors++;
                $display("FAIL rr_resp%0d resp_valid=%b result=%h required %b/%h",
                         g, resp_valid, resp_result, 4'(1) << exp_id, 32'(exp_id + 11));
            end
            tick();
        end
        req_valid  = 4'b0;
        resp_ready = 4'b0;
        #1;
    endtask

    task automatic test_alu_flags();
        logic [31:0] r;
        logic ov, co, z;
        run_op(0, 32'd3, 32'd5, 3'b110, r, ov, co, z);
        checks++;
        if (r !== 32'hFFFFFFFE || {ov, co, z} !== 3'b010) begin
            errors++; $display("FAIL sub_3_5 result=%h ovf/co/z=%b required FFFFFFFE/010", r, {ov, co, z});
        end
        run_op(0, 32'hFFFFFFFF, 32'd1, 3'b111, r, ov, co, z);
        checks++;
        if (r !== 32'h1) begin
            errors++; $display("FAIL slt_neg1_1 result=%h required 00000001", r);
        end
        run_op(0, 32'd5, 32'd3, 3'b111, r, ov, co, z);
        checks++;
        if (r !== 32'h0 || z !== 1'b1) begin
            errors++; $display("FAIL slt_5_3 result=%h zero=%b required 0/1", r, z);
        end
        run_op(0, 32'hFFFFFFFF, 32'd1, 3'b010, r, ov, co, z);
        checks++;
        if (r !== 32'h0 || {ov, co, z} !== 3'b011) begin
            errors++; $display("FAIL add_carry result=%h ovf/co/z=%b required 0/011", r, {ov, co, z});
        end
        run_op(0, 32'hF0F0_00F0, 32'h0F0F_0F0F, 3'b000, r, ov, co, z);
        checks++;
        if (r !== 32'h0000_0000 || z !== 1'b1) begin
            errors++; $display("FAIL and_zero result=%h zero=%b required 0/1", r, z);
        end
        run_op(0, 32'hF0F0_00F0, 32'h0F0F_0F0F, 3'b001, r, ov, co, z);
        checks++;
        if (r !== 32'hFFFF_0FFF || z !== 1'b0) begin
            errors++; $display("FAIL or result=%h zero=%b required FFFF0FFF/0", r, z);
        end
        run_op(0, 32'h1234, 32'h5678, 3'b011, r, ov, co, z);
        checks++;
        if (r !== 32'h0 || z !== 1'b1) begin
            errors++; $display("FAIL undef_op result=%h zero=%b required 0/1", r, z);
        end
    endtask

    task automatic test_back_pressure();
        // rr_ptr is 1 after the previous ops on requester 0.
        req_a[1*32 +: 32] = 32'd100;
        req_b[1*32 +: 32] = 32'd23;
        req_op[1*3 +: 3]  = 3'b010;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant req_ready=%b required 0010", req_ready);
        end
        tick();
        req_valid = 4'hF;
        tick();
        resp_ready = 4'b1101;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 4'b0010 || resp_result !== 32'd123 || busy !== 1'b1 || req_ready !== 4'b0) begin
                errors++;
                $display("FAIL bp_hold%0d resp_valid=%b result=%h busy=%b req_ready=%b required 0010/7b/1/0000",
                         c, resp_valid, resp_result, busy, req_ready);
            end
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release busy=%b resp_valid=%b req_ready=%b required 0/0000/0100",
                     busy, resp_valid, req_ready);
        end
        req_valid  = 4'b0;
        resp_ready = 4'b0;
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic ov, co, z;
        req_a[2*32 +: 32] = 32'd7;
        req_b[2*32 +: 32] = 32'd8;
        req_op[2*3 +: 3]  = 3'b010;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || resp_valid !== 4'b0 || req_ready !== 4'b0 ||
            resp_result !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async busy=%b grant=%0d resp_valid=%b req_ready=%b result=%h required all 0",
                     busy, grant_id, resp_valid, req_ready, resp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0) begin
            errors++; $display("FAIL midrst_no_resp busy=%b resp_valid=%b required 0/0000", busy, resp_valid);
        end
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL midrst_rr_ptr req_ready=%b required 0010", req_ready);
        end
        run_op(3, 32'd1, 32'd2, 3'b010, r, ov, co, z);
        checks++;
        if (r !== 32'd3) begin
            errors++; $display("FAIL midrst_op3 result=%h required 00000003", r);
        end
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midrst_next req_ready=%b required 0001", req_ready);
        end
        req_valid = 4'b0;
        #1;
    endtask

    task automatic test_stats();
        logic [31:0] r;
        logic ov, co, z;
        do_reset();
        for (int n = 0; n < 3; n++) run_op(1, 32'(n), 32'd1, 3'b010, r, ov, co, z);
        run_op(2, 32'd9, 32'd9, 3'b001, r, ov, co, z);
`ifdef ALU_SHARE_STATS_EN
        checks++;
        if (stat_count !== {16'd0, 16'd1, 16'd3, 16'd0}) begin
            errors++; $display("FAIL stats got %h required 0000000100030000", stat_count);
        end
`else
        checks++;
        if (stat_count !== 64'h0) begin
            errors++; $display("FAIL stats_disabled got %h required 0", stat_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_alu_flags();
        test_back_pressure();
        test_reset_mid_op();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
